mips_inst_encoder: RTL and testbench
====================================

// Module: mips_inst_encoder
// PURPOSE
//  Program loader for the single-cycle core: accepts instruction-build requests (class + fields),
//  encodes each into a 32-bit MIPS word using the same opcode set the main decoder recognises
//  (R-type, LW, SW, BEQ, ADDI, J), and writes the words into instruction memory at consecutive word
//  addresses. Holds the CPU in reset until the last word is written plus a hold delay.
// PARAMETERS
//  ADDR_W    6   imem word-address width; DEPTH = 2**ADDR_W words
//  RST_HOLD  4   cycles cpu_resetn stays low after the last word's write (1..255)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  resetn       in   1       asynchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid & req_ready
//  req_kind     in   3       0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=J 6,7=illegal
//  req_rs/rt/rd in   5 each  register fields
//  req_funct    in   6       R-type funct (shamt always 0)
//  req_imm      in   16      I-type immediate
//  req_target   in   26      J target
//  req_last     in   1       marks final instruction of the program
//  imem_we      out  1       write strobe; word transfers when imem_we & imem_ready
//  imem_ready   in   1       memory accepts write this cycle
//  imem_addr    out  ADDR_W  word address
//  imem_wdata   out  32      encoded instruction
//  err_illegal  out  1       sticky: illegal kind seen
//  err_ovf      out  1       sticky: write attempted past DEPTH-1
//  load_done    out  1       high in DONE state
//  cpu_resetn   out  1       core reset, low until RUN
// BEHAVIOUR
//  Reset (async, resetn=0): state=LOAD, addr counter=0, pipeline reg empty, imem_we=0, imem_addr=0,
//   imem_wdata=0, err_*=0, load_done=0, cpu_resetn=0, hold counter=0. Reset mid-load abandons all.
//  Encoding: RTYPE {6'b000000,rs,rt,rd,5'b0,funct}; LW {6'b100011,rs,rt,imm}; SW {6'b101011,rs,rt,imm};
//   BEQ {6'b000100,rs,rt,imm}; ADDI {6'b001000,rs,rt,imm}; J {6'b000010,target}. Unused fields ignored.
//  Pipeline: one output register. req_ready = (state==LOAD) & (reg empty | imem_ready).
//   Accepted legal request -> reg loads {word, addr counter, last}; imem_we=1 from the next cycle
//   (latency 1). imem_we/addr/wdata hold stable while imem_ready=0. Full throughput: 1 word/cycle.
//  Address counter increments on each accepted legal request. Accepted when counter already wrapped
//   past DEPTH-1 (tracked by a 1-bit ovf flag): word dropped, err_ovf set, counter unchanged.
//  Illegal kind accepted: nothing written, err_illegal set, counter unchanged; if req_last also set,
//   it still ends the program (enters HOLD once pipeline drains).
//  FSM: LOAD -> HOLD when the word tagged last completes (imem_we & imem_ready) or last-tagged
//   dropped/illegal request accepted with reg empty; req_ready=0 outside LOAD.
//   HOLD: counter counts 1..RST_HOLD; at RST_HOLD -> DONE. DONE: load_done=1, cpu_resetn=1,
//   stays until resetn. No new requests accepted in HOLD/DONE.
//  Simultaneous accept and drain in same cycle: reg replaced, no bubble, no duplicate write.
// TESTING
//  ADDI rs=0 rt=8 imm=16'h0005, last, ready=1 -> cycle+1 we=1 addr=0 wdata=32'h20080005;
//   cpu_resetn rises exactly RST_HOLD+1 cycles after the write.
//  RTYPE rs=9 rt=10 rd=8 funct=6'h20, LW rs=0 rt=9 imm=4, J target=26'h10 back-to-back ->
//   wdata 32'h012A4020, 32'h8C090004, 32'h08000010 at addr 0,1,2, one per cycle.
//  imem_ready=0 for 3 cycles on 2nd word -> req_ready=0, addr/wdata stable, no loss/duplication.
//  kind=6 between two SW -> err_illegal=1, SWs at addr 0 and 1, no gap.
//  ADDR_W=2, 5 legal requests -> addrs 0..3 written, 5th dropped, err_ovf=1.
//  resetn low during HOLD -> all outputs to reset values, cpu_resetn stays 0, LOAD resumes at addr 0.

Source files
------------

// File: rtl/mips_inst_encoder.sv
// Program loader: encodes instruction-build requests into MIPS words, streams them into
// instruction memory at consecutive word addresses, then releases the core after a hold delay.
module mips_inst_encoder #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_illegal,
    output logic              err_ovf,
    output logic              load_done,
    output logic              cpu_resetn
);
    typedef enum logic [1:0] {S_LOAD, S_HOLD, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ovf;
    logic              r_valid;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err_ill;
    logic              r_err_ovf;
    logic [7:0]        r_hold;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;
    logic              w_write;
    logic              w_drain;
    logic              w_end;
    logic              w_hold_end;

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (req_kind)
            3'd0:    w_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, req_funct};
            3'd1:    w_word = {6'b100011, req_rs, req_rt, req_imm};
            3'd2:    w_word = {6'b101011, req_rs, req_rt, req_imm};
            3'd3:    w_word = {6'b000100, req_rs, req_rt, req_imm};
            3'd4:    w_word = {6'b001000, req_rs, req_rt, req_imm};
            3'd5:    w_word = {6'b000010, req_target};
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept   = req_valid & req_ready;
    assign w_write    = w_accept & w_legal & ~r_ovf;
    assign w_drain    = r_valid & imem_ready;
    // A dropped/illegal last request can only be accepted when the register is empty or draining,
    // so the program ends on that same edge.
    assign w_end      = (w_drain & r_last) | (w_accept & ~w_write & req_last);
    assign w_hold_end = (r_hold == 8'(RST_HOLD));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_write) begin
            r_valid <= 1'b1;
            r_last  <= req_last;
            r_addr  <= r_cnt;
            r_wdata <= w_word;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_write) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == '1) r_ovf <= 1'b1;
            end
            if (w_accept & ~w_legal) r_err_ill <= 1'b1;
            if (w_accept & w_legal & r_ovf) r_err_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold <= '0;
        end else if (r_state == S_HOLD && !w_hold_end) begin
            r_hold <= r_hold + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_LOAD;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_end) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_hold_end) w_state_nxt = S_DONE;
            default: w_state_nxt = S_DONE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_LOAD) & (~r_valid | imem_ready);
        load_done  = (r_state == S_DONE);
        cpu_resetn = (r_state == S_DONE);
    end

    assign imem_we     = r_valid;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign err_illegal = r_err_ill;
    assign err_ovf     = r_err_ovf;
endmodule

// File: tb/tb_mips_inst_encoder.sv
// Bench for mips_inst_encoder: scoreboard model of the loader plus directed program loads.
module tb_mips_inst_encoder;
    localparam int unsigned AW    = 2;
    localparam int unsigned HOLD  = 4;
    localparam int          DEPTH = 1 << AW;
    localparam int          NEVER = 1 << 30;

    logic          clk;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_kind;
    logic [4:0]    req_rs;
    logic [4:0]    req_rt;
    logic [4:0]    req_rd;
    logic [5:0]    req_funct;
    logic [15:0]   req_imm;
    logic [25:0]   req_target;
    logic          req_last;
    logic          imem_we;
    logic          imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          err_illegal;
    logic          err_ovf;
    logic          load_done;
    logic          cpu_resetn;

    mips_inst_encoder #(.ADDR_W(AW), .RST_HOLD(HOLD)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .err_illegal(err_illegal), .err_ovf(err_ovf), .load_done(load_done), .cpu_resetn(cpu_resetn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int addr; logic [31:0] word; bit last;} exp_t;
    typedef struct {int addr; logic [31:0] word; int cyc;} wr_t;
    exp_t q[$];
    wr_t  wlog[$];

    int n_cmp = 0;
    int n_err = 0;

    // driver-side model state
    int m_addr;
    bit m_ovf;
    int m_ill_cyc  = NEVER;
    int m_ovf_cyc  = NEVER;
    int m_end_d    = NEVER;
    int m_done_d   = NEVER;
    // compare-side model state (end of program via a completed last write)
    int m_end_w    = NEVER;
    int m_done_w   = NEVER;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [31:0] enc(input int kind, input int rs, input int rt, input int rd,
                                        input int funct, input int imm, input int target);
        bit [31:0] op;
        bit [31:0] w;
        case (kind)
            1: op = 35;
            2: op = 43;
            3: op = 4;
            4: op = 8;
            5: op = 2;
            default: op = 0;
        endcase
        if (kind == 5) w = (op << 26) + 32'(target);
        else if (kind == 0) w = (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + 32'(funct);
        else w = (op << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
        return w;
    endfunction

    // compare process: every cycle outputs are checked against the model
    initial begin
        logic          stall_prev = 1'b0;
        logic [AW-1:0] prev_addr  = '0;
        logic [31:0]   prev_wdata = '0;
        exp_t          e;
        wr_t           wr;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_we", imem_we, 0);
                chk("rst_addr", imem_addr, 0);
                chk("rst_wdata", imem_wdata, 0);
                chk("rst_err_illegal", err_illegal, 0);
                chk("rst_err_ovf", err_ovf, 0);
                chk("rst_load_done", load_done, 0);
                chk("rst_cpu_resetn", cpu_resetn, 0);
                q.delete();
                wlog.delete();
                m_end_w    = NEVER;
                m_done_w   = NEVER;
                stall_prev = 1'b0;
            end else begin
                chk("cpu_resetn", cpu_resetn, cyc >= imin(m_done_w, m_done_d));
                chk("load_done", load_done, cyc >= imin(m_done_w, m_done_d));
                chk("err_illegal", err_illegal, cyc >= m_ill_cyc);
                chk("err_ovf", err_ovf, cyc >= m_ovf_cyc);
                chk("req_ready", req_ready,
                    (cyc < imin(m_end_w, m_end_d)) && (!imem_we || imem_ready));
                if (stall_prev) begin
                    chk("stall_we", imem_we, 1);
                    chk("stall_addr", imem_addr, prev_addr);
                    chk("stall_wdata", imem_wdata, prev_wdata);
                end
                if (imem_we && imem_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_write", imem_we, 0);
                    end else begin
                        e = q.pop_front();
                        chk("wr_addr", imem_addr, e.addr);
                        chk("wr_wdata", imem_wdata, e.word);
                        wr.addr = int'(imem_addr);
                        wr.word = imem_wdata;
                        wr.cyc  = cyc + 1;
                        wlog.push_back(wr);
                        if (e.last) begin
                            m_end_w  = cyc + 1;
                            m_done_w = cyc + 1 + HOLD + 1;
                        end
                    end
                end
                stall_prev = imem_we && !imem_ready;
                prev_addr  = imem_addr;
                prev_wdata = imem_wdata;
            end
        end
    end

    task automatic send(input int kind, input int rs, input int rt, input int rd, input int funct,
                        input int imm, input int target, input bit last, output int acc_cyc);
        bit   acc = 0;
        exp_t e;
        req_kind   = 3'(kind);
        req_rs     = 5'(rs);
        req_rt     = 5'(rt);
        req_rd     = 5'(rd);
        req_funct  = 6'(funct);
        req_imm    = 16'(imm);
        req_target = 26'(target);
        req_last   = last;
        req_valid  = 1'b1;
        acc_cyc    = -1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1;
                if (kind > 5) begin
                    if (m_ill_cyc == NEVER) m_ill_cyc = cyc + 1;
                    if (last) begin m_end_d = cyc + 1; m_done_d = cyc + 1 + HOLD + 1; end
                end else if (m_ovf) begin
                    if (m_ovf_cyc == NEVER) m_ovf_cyc = cyc + 1;
                    if (last) begin m_end_d = cyc + 1; m_done_d = cyc + 1 + HOLD + 1; end
                end else begin
                    e.addr = m_addr;
                    e.word = enc(kind, rs, rt, rd, funct, imm, target);
                    e.last = last;
                    q.push_back(e);
                    m_addr++;
                    if (m_addr == DEPTH) begin m_addr = 0; m_ovf = 1; end
                end
            end
            @(posedge clk);
            #1;
            if (acc) acc_cyc = cyc;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn    = 1'b0;
        req_valid = 1'b0;
        m_addr    = 0;
        m_ovf     = 0;
        m_ill_cyc = NEVER;
        m_ovf_cyc = NEVER;
        m_end_d   = NEVER;
        m_done_d  = NEVER;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            seen = cpu_resetn;
        end
        chk("done_reached", load_done, 1);
    endtask

    task automatic stall_second();
        bit stalled = 0;
        for (int t = 0; t < 40 && !stalled; t++) begin
            @(posedge clk);
            #1;
            if (imem_we && imem_addr == 1) begin
                imem_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                imem_ready = 1'b1;
                stalled = 1;
            end
        end
        chk("stall_applied", 32'(stalled), 1);
    endtask

    task automatic send_three();
        int a;
        send(0, 9, 10, 8, 6'h20, 0, 0, 0, a);
        send(1, 0, 9, 0, 0, 4, 0, 0, a);
        send(5, 0, 0, 0, 0, 0, 26'h10, 1, a);
    endtask

    initial begin
        int a;
        int d;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_kind   = '0;
        req_rs     = '0;
        req_rt     = '0;
        req_rd     = '0;
        req_funct  = '0;
        req_imm    = '0;
        req_target = '0;
        req_last   = 1'b0;
        imem_ready = 1'b1;
        do_reset();

        // single ADDI, release timing
        send(4, 0, 8, 0, 0, 16'h0005, 0, 1, a);
        @(negedge clk);
        chk("t1_we", imem_we, 1);
        chk("t1_addr", imem_addr, 0);
        chk("t1_wdata", imem_wdata, 32'h20080005);
        wait_done();
        chk("t1_release_cycle", cyc, a + 1 + HOLD + 1);

        // back-to-back RTYPE, LW, J
        do_reset();
        send_three();
        wait_done();
        chk("t2_count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("t2_w0", wlog[0].word, 32'h012A4020);
            chk("t2_w1", wlog[1].word, 32'h8C090004);
            chk("t2_w2", wlog[2].word, 32'h08000010);
            chk("t2_a2", wlog[2].addr, 2);
            chk("t2_gap01", wlog[1].cyc - wlog[0].cyc, 1);
            chk("t2_gap12", wlog[2].cyc - wlog[1].cyc, 1);
        end

        // memory back-pressure on the second word
        do_reset();
        fork
            send_three();
            stall_second();
        join
        wait_done();
        chk("t3_count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("t3_w1", wlog[1].word, 32'h8C090004);
            chk("t3_gap01", wlog[1].cyc - wlog[0].cyc, 4);
            chk("t3_gap12", wlog[2].cyc - wlog[1].cyc, 1);
        end

        // illegal kind between two stores
        do_reset();
        send(2, 1, 2, 0, 0, 8, 0, 0, a);
        send(6, 0, 0, 0, 0, 0, 0, 0, a);
        send(2, 3, 4, 0, 0, 12, 0, 1, a);
        wait_done();
        chk("t4_err_illegal", err_illegal, 1);
        chk("t4_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t4_w0", wlog[0].word, 32'hAC220008);
            chk("t4_w1", wlog[1].word, 32'hAC64000C);
            chk("t4_a1", wlog[1].addr, 1);
        end

        // address overflow with DEPTH=4
        do_reset();
        for (int i = 0; i < 5; i++) send(4, 0, i, 0, 0, i, 0, i == 4, a);
        wait_done();
        chk("t5_count", wlog.size(), 4);
        chk("t5_err_ovf", err_ovf, 1);
        if (wlog.size() == 4) chk("t5_a3", wlog[3].addr, 3);

        // reset during HOLD
        do_reset();
        send(4, 0, 8, 0, 0, 16'h0005, 0, 1, a);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        resetn    = 1'b0;
        m_addr    = 0;
        m_ovf     = 0;
        m_ill_cyc = NEVER;
        m_ovf_cyc = NEVER;
        m_end_d   = NEVER;
        m_done_d  = NEVER;
        for (int i = 0; i < HOLD + 4; i++) begin
            @(negedge clk);
            chk("t6_cpu_resetn_low", cpu_resetn, 0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send(5, 0, 0, 0, 0, 0, 26'h3, 1, d);
        wait_done();
        chk("t6_count", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("t6_addr", wlog[0].addr, 0);
            chk("t6_word", wlog[0].word, 32'h08000003);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
